// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: per-port valid/ready request channel and response pulses between requesters and sram_arbiter.
interface sram_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_PORTS-1:0]            reqValid;
    logic [NUM_PORTS-1:0]            reqWrite;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] reqAddr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] reqData;
    logic [NUM_PORTS-1:0]            reqReady;
    logic [NUM_PORTS-1:0]            rspValid;
    logic [DATA_WIDTH-1:0]           rspData;
    modport master (output reqValid, reqWrite, reqAddr, reqData, input reqReady, rspValid, rspData);
    modport slave  (input reqValid, reqWrite, reqAddr, reqData, output reqReady, rspValid, rspData);
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: multi-port arbiter and strobe timing controller for one asynchronous SRAM.
// Define SRAM_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead of round-robin.
module sram_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int ADDR_WIDTH    = 18,
    parameter int DATA_WIDTH    = 16,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_arbiter_if.slave         bus,
    output logic [ADDR_WIDTH-1:0] memAddrBus,
    inout  wire  [DATA_WIDTH-1:0] memDataBus,
    output logic                  memEnable,
    output logic                  memRead,
    output logic                  memWrite
);
    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int CW = STROBE_CYCLES > 1 ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} stateType;

    stateType              state;
    logic [PW-1:0]         port, win, cand;
    logic [CW-1:0]         cnt;
    logic                  isWrite, drive;
    logic [DATA_WIDTH-1:0] wData;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
    logic [PW-1:0]         ptr;
`endif

    // Scan from the far end so the nearest requester to the search start wins last.
    always_comb begin
        win  = '0;
        cand = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
            cand = PW'(k);
`else
            cand = PW'((int'(ptr) + k) % NUM_PORTS);
`endif
            if (bus.reqValid[cand]) win = cand;
        end
        bus.reqReady = (state == IDLE && |bus.reqValid) ? NUM_PORTS'(1) << win : '0;
    end

    assign memDataBus = drive ? wData : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            port         <= '0;
            isWrite      <= 1'b0;
            wData        <= '0;
            cnt          <= '0;
            drive        <= 1'b0;
            bus.rspValid <= '0;
            bus.rspData  <= '0;
            memAddrBus   <= '0;
            memEnable    <= 1'b1;
            memRead      <= 1'b1;
            memWrite     <= 1'b1;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
            ptr          <= '0;
`endif
        end else begin
            bus.rspValid <= '0;
            case (state)
                IDLE: if (|bus.reqValid) begin
                    port       <= win;
                    isWrite    <= bus.reqWrite[win];
                    drive      <= bus.reqWrite[win];
                    memAddrBus <= bus.reqAddr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    wData      <= bus.reqData[win*DATA_WIDTH +: DATA_WIDTH];
                    memEnable  <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIORITY_EN
                    ptr        <= (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
`endif
                    state      <= SETUP;
                end
                SETUP: begin
                    memRead  <= isWrite;
                    memWrite <= !isWrite;
                    cnt      <= CW'(STROBE_CYCLES - 1);
                    state    <= STROBE;
                end
                // Read data is sampled on the last strobe edge, before output enable rises.
                STROBE: if (cnt == '0) begin
                    memRead      <= 1'b1;
                    memWrite     <= 1'b1;
                    bus.rspValid <= NUM_PORTS'(1) << port;
                    bus.rspData  <= isWrite ? '0 : memDataBus;
                    state        <= RECOVER;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RECOVER: begin
                    memEnable <= 1'b1;
                    drive     <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sram_arbiter with 2-port/strobe-2 and 4-port/strobe-1 instances.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int bothLow = 0;

    sram_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(18), .DATA_WIDTH(16)) ifA();
    sram_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(18), .DATA_WIDTH(16)) ifB();

    wire  [15:0] dataA, dataB;
    logic [17:0] addrA, addrB;
    logic        enA, rdA, wrA, enB, rdB, wrB;
    logic        probeEn = 1'b0;
    logic [15:0] memA [0:1023];

    sram_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(18), .DATA_WIDTH(16), .STROBE_CYCLES(2)) dutA (
        .clk(clk), .rst(rst), .bus(ifA), .memAddrBus(addrA), .memDataBus(dataA),
        .memEnable(enA), .memRead(rdA), .memWrite(wrA));

    sram_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(18), .DATA_WIDTH(16), .STROBE_CYCLES(1)) dutB (
        .clk(clk), .rst(rst), .bus(ifB), .memAddrBus(addrB), .memDataBus(dataB),
        .memEnable(enB), .memRead(rdB), .memWrite(wrB));

    // SRAM models: A is a real array, B returns a pattern derived from the address.
    assign dataA = (!enA && !rdA) ? memA[addrA[9:0]] : 16'bz;
    assign dataA = probeEn ? 16'h5A5A : 16'bz;
    assign dataB = (!enB && !rdB) ? (addrB[15:0] ^ 16'hC3C3) : 16'bz;

    always @(negedge clk) begin
        if (!enA && !wrA) memA[addrA[9:0]] <= dataA;
        if ((!rdA && !wrA) || (!rdB && !wrB)) bothLow++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic accessA(input int p, input logic w, input logic [17:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output int lat, output logic [7:0] rdPat,
                           output logic [7:0] wrPat, output logic [15:0] busVal, output logic [1:0] other);
        int k = 0;
        @(negedge clk);
        ifA.reqValid = 2'b1 << p;
        ifA.reqWrite[p] = w;
        ifA.reqAddr[p*18 +: 18] = a;
        ifA.reqData[p*16 +: 16] = d;
        #1;
        while (!ifA.reqReady[p] && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("acceptTimeout", 32'(k < 20), 32'd1);
        rd = '0; lat = 0; busVal = '0; other = '0;
        rdPat = '1; wrPat = '1;
        rdPat[0] = rdA;
        wrPat[0] = wrA;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) ifA.reqValid = '0;
            rdPat[c] = rdA;
            wrPat[c] = wrA;
            if (!wrA) busVal = dataA;
            if (ifA.rspValid[p] && lat == 0) begin
                lat = c;
                rd = ifA.rspData;
            end
            other |= ifA.rspValid & ~(2'b1 << p);
        end
    endtask

    logic [15:0] rd, busVal, mw;
    logic [7:0]  rdPat, wrPat;
    logic [5:0]  rdPatB;
    logic [1:0]  other;
    logic [3:0]  grants, otherB;
    int          lat, n, bad, seen;

    initial begin
        for (int i = 0; i < 1024; i++) memA[i] = 16'h0000;
        memA[10'h123] = 16'hBEEF;
        memA[10'h055] = 16'h1111;
        ifA.reqValid = '0; ifA.reqWrite = '0; ifA.reqAddr = '0; ifA.reqData = '0;
        ifB.reqValid = '0; ifB.reqWrite = '0; ifB.reqAddr = '0; ifB.reqData = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rstEnable", 32'(enA), 32'd1);
        check("rstStrobes", {30'd0, rdA, wrA}, 32'd3);
        check("rstRsp", {30'd0, ifA.rspValid}, 32'd0);
        check("rstRspData", 32'(ifA.rspData), 32'd0);
        check("rstAddr", 32'(addrA), 32'd0);
        check("rstReady", 32'(ifA.reqReady), 32'd0);
        @(negedge clk) rst = 1'b0;

        // Single read by port 1
        accessA(1, 1'b0, 18'h00123, 16'h0, rd, lat, rdPat, wrPat, busVal, other);
        check("rdData", 32'(rd), 32'hBEEF);
        check("rdLatency", 32'(lat), 32'd4);
        check("rdReadPat", 32'(rdPat), 32'hF3);
        check("rdWritePat", 32'(wrPat), 32'hFF);
        check("rdOtherRsp", 32'(other), 32'd0);
        check("rdAddrHeld", 32'(addrA), 32'h00123);

        // Write then read back by port 0
        accessA(0, 1'b1, 18'h3FFFF, 16'h1234, rd, lat, rdPat, wrPat, busVal, other);
        check("wrRspData", 32'(rd), 32'd0);
        check("wrLatency", 32'(lat), 32'd4);
        check("wrWritePat", 32'(wrPat), 32'hF3);
        check("wrReadPat", 32'(rdPat), 32'hFF);
        check("wrBus", 32'(busVal), 32'h1234);
        check("wrMem", 32'(memA[10'h3FF]), 32'h1234);
        accessA(0, 1'b0, 18'h3FFFF, 16'h0, rd, lat, rdPat, wrPat, busVal, other);
        check("rbData", 32'(rd), 32'h1234);
        check("rbOtherRsp", 32'(other), 32'd0);

        // Contention from a fresh reset so the pointer starts at port 0
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        ifA.reqValid = 2'b11;
        ifA.reqWrite = 2'b00;
        ifA.reqAddr = {18'h3FFFF, 18'h00123};
        n = 0; grants = '0; bad = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            if (ifA.reqReady == 2'b11) bad++;
            if (ifA.reqReady != 2'b00) begin
                grants[n] = ifA.reqReady[1];
                n++;
            end
            @(negedge clk);
        end
        ifA.reqValid = '0;
        check("ctCount", 32'(n), 32'd4);
        check("ctOneHot", 32'(bad), 32'd0);
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        check("ctOrder", 32'(grants), 32'h0);
`else
        check("ctOrder", 32'(grants), 32'hA);
`endif
        repeat (6) @(negedge clk);

        // Reset in the middle of a write strobe
        ifA.reqValid = 2'b01;
        ifA.reqWrite = 2'b01;
        ifA.reqAddr[17:0] = 18'h00055;
        ifA.reqData[15:0] = 16'hA5A5;
        #1 check("mrReady", 32'(ifA.reqReady), 32'd1);
        @(posedge clk);
        @(negedge clk) ifA.reqValid = '0;
        @(posedge clk);
        #2;
        check("mrPreWrite", 32'(wrA), 32'd0);
        check("mrPreBus", 32'(dataA), 32'hA5A5);
        rst = 1'b1;
        #1;
        check("mrWrite", 32'(wrA), 32'd1);
        check("mrEnable", 32'(enA), 32'd1);
        check("mrRsp", 32'(ifA.rspValid), 32'd0);
        probeEn = 1'b1;
        #1 check("mrBusFree", 32'(dataA), 32'h5A5A);
        probeEn = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifA.rspValid != 2'b00) seen++;
        end
        check("mrNoRsp", 32'(seen), 32'd0);
        mw = memA[10'h055];
        check("mrWord", 32'(mw == 16'h1111 || mw == 16'hA5A5), 32'd1);
        accessA(0, 1'b0, 18'h00055, 16'h0, rd, lat, rdPat, wrPat, busVal, other);
        check("mrAfterLat", 32'(lat), 32'd4);
        check("mrAfterData", 32'(rd), 32'(mw));

        // Four ports, one-cycle strobe: wrap after port 3
        @(negedge clk);
        ifB.reqValid = 4'b1000;
        ifB.reqAddr[3*18 +: 18] = 18'h00777;
        #1 check("b3Ready", 32'(ifB.reqReady), 32'h8);
        @(negedge clk) ifB.reqValid = '0;
        repeat (3) @(negedge clk);
        ifB.reqValid = 4'b1010;
        ifB.reqAddr[1*18 +: 18] = 18'h00222;
        ifB.reqAddr[3*18 +: 18] = 18'h00333;
        #1 check("bWrap", 32'(ifB.reqReady), 32'h2);
        lat = 0; rd = '0; otherB = '0; rdPatB = '1;
        rdPatB[0] = rdB;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) ifB.reqValid = '0;
            rdPatB[c] = rdB;
            if (ifB.rspValid[1] && lat == 0) begin
                lat = c;
                rd = ifB.rspData;
            end
            otherB |= ifB.rspValid & 4'b1101;
        end
        check("bLatency", 32'(lat), 32'd3);
        check("bData", 32'(rd), 32'hC1E1);
        check("bReadPat", 32'(rdPatB), 32'h3B);
        check("bOtherRsp", 32'(otherB), 32'd0);

        check("strobeExcl", 32'(bothLow), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised multi-port arbiter and timing controller for the board's single asynchronous external SRAM. Replaces the fixed two-port memory controller: any number of requesters (instruction fetch, data access, graphics, DMA) share the SRAM through a per-port valid/ready request channel and a per-port response pulse. Sits in the mother board between the address-mapping logic and the SRAM pins, and owns `memAddrBus`, `memDataBus` and the three active-low strobes.

## Interface
- `NUM_PORTS`, 2: number of requester ports (1..8).
- `ADDR_WIDTH`, 18: SRAM word address width.
- `DATA_WIDTH`, 16: SRAM data width.
- `STROBE_CYCLES`, 2: cycles `memRead`/`memWrite` are held low (≥1).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `reqValid`  in  NUM_PORTS  port i requests an access.
- `reqWrite`  in  NUM_PORTS  1 = write, 0 = read.
- `reqAddr`  in  NUM_PORTS*ADDR_WIDTH  port i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `reqData`  in  NUM_PORTS*DATA_WIDTH  write data, same packing.
- `reqReady`  out  NUM_PORTS  one-hot accept; the request is taken on the edge where valid & ready.
- `rspValid`  out  NUM_PORTS  one-cycle completion pulse for the accepted port.
- `rspData`  out  DATA_WIDTH  read data, valid with `rspValid`; 0 for writes.
- `memAddrBus`  out  ADDR_WIDTH  SRAM address.
- `memDataBus`  inout  DATA_WIDTH  SRAM data; high-Z unless writing.
- `memEnable`, `memRead`, `memWrite`  out  1 each  active-low chip enable, output enable, write enable.

## Operation
- FSM states: IDLE, SETUP, STROBE, RECOVER.
- IDLE: if any `reqValid`, select the winner, assert `reqReady[w]` combinationally. At the edge, latch port index, write flag, address and data, then go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): drive `memAddrBus`, `memEnable`=0. For a write, drive `memDataBus`=latched data.
- STROBE (`STROBE_CYCLES` cycles, down-counter): `memRead`=0 (read) or `memWrite`=0 (write). Address, enable and write data are held. On a read, `memDataBus` is sampled on the final STROBE edge.
- RECOVER (1 cycle): strobes high, `memEnable` still 0, address and write data held for hold time. `rspValid[w]`=1, `rspData`=captured word (read) or 0 (write). Return to IDLE.
- Round-robin: the search starts at (last granted + 1) mod NUM_PORTS and wraps. It starts at port 0 after reset. The pointer updates only on an accept.
- Requesters must hold `reqValid` and the fields stable until `reqReady`. Dropping `reqValid` before accept is legal; the request is withdrawn.
- A port may re-request in the cycle it sees `rspValid`. It competes in the next IDLE.
- `reqValid` from non-winners and from any port outside IDLE is ignored; `reqReady` stays 0.
- `memRead` and `memWrite` are never low together. `memDataBus` is never driven while `memRead` is low.

## Timing
- Reset values: state IDLE, `reqReady`=0, `rspValid`=0, `rspData`=0, `memAddrBus`=0, `memEnable`=`memRead`=`memWrite`=1, `memDataBus` high-Z, RR pointer so port 0 has priority.
- Accept at cycle 0 → SETUP cycle 1 → STROBE cycles 2..1+STROBE_CYCLES → `rspValid` at cycle 2+STROBE_CYCLES.
- Throughput: one access per 3+STROBE_CYCLES cycles; default 5.
- Reset asserted mid-access: outputs go to reset values immediately (asynchronous). The in-flight access is abandoned and no `rspValid` is issued.
- Reset release: first accept possible on the first rising edge with `rst`=0.
- All outputs except `reqReady` are registered.

## Configuration
- `SRAM_ARB_FIXED_PRIORITY_EN` defined: fixed priority, lowest index wins. The round-robin pointer is removed.
- Undefined (default): round-robin as above.

## Test plan
- Single read, defaults: SRAM model holds 0xBEEF at 0x00123; port 1 reads 0x00123 at cycle 0. Required: `memRead` low cycles 2–3, `rspValid[1]` at cycle 4 with `rspData`=0xBEEF, `rspValid[0]`=0.
- Write then read: port 0 writes 0x1234 to 0x3FFFF. Required: `memWrite` low 2 cycles with the bus driven 0x1234, `rspData`=0. Port 0 then reads 0x3FFFF and gets 0x1234.
- Contention: both ports hold `reqValid` continuously for 4 accesses. Round-robin build: grants alternate 0,1,0,1. With `SRAM_ARB_FIXED_PRIORITY_EN`: port 0 wins all 4.
- `NUM_PORTS`=4, `STROBE_CYCLES`=1: ports 1 and 3 request after port 3's last grant. Required: port 1 wins first (wrap). Response latency is 3 cycles.
- Reset mid-STROBE of a write: assert `rst` at cycle 2. Required: `memWrite`=`memEnable`=1 and the bus high-Z within the same cycle, no `rspValid`. After release, the SRAM word is unchanged or fully written, and a new request is accepted normally.
